conv_window_ctrl: RTL and testbench

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

---
 rtl/lenet_pkg.sv | 19 +
 rtl/conv_window_ctrl_if.sv | 25 ++
 rtl/conv_window_ctrl_wrap_counter.sv | 36 +++
 rtl/conv_window_ctrl.sv | 117 +++++++++++
 tb/tb_conv_window_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lenet_pkg.sv
// Shared types and default geometry for the sliding-window convolution front end.
package lenet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned IMG_W_DEF = 32'd32;
  localparam int unsigned IMG_H_DEF = 32'd32;
  localparam int unsigned K_DEF     = 32'd5;

  // Bit width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle between the window controller and its neighbours.
import lenet_pkg::*;

interface conv_window_ctrl_if #(
  parameter int unsigned ROW_W = width_of(IMG_H_DEF - K_DEF + 32'd1),
  parameter int unsigned COL_W = width_of(IMG_W_DEF - K_DEF + 32'd1)
);
  logic             pix_valid;
  logic             pix_ready;
  logic             shift_en;
  logic             win_valid;
  logic             win_ready;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;

  modport master (
    output pix_valid, win_ready,
    input  pix_ready, shift_en, win_valid, out_row, out_col
  );

  modport slave (
    input  pix_valid, win_ready,
    output pix_ready, shift_en, win_valid, out_row, out_col
  );
endinterface

// File: rtl/conv_window_ctrl_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the enabled step from MAX back to 0.
import lenet_pkg::*;

module wrap_counter #(
  parameter int unsigned MAX = 32'd31,
  parameter int unsigned W   = width_of(MAX + 32'd1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);
  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] count_r;

  assign wrap  = en & (count_r == MAX_V);
  assign count = count_r;

  // Count register: clear dominates enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= (count_r == MAX_V) ? '0 : (count_r + ONE_V);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Raster-scan controller for a KxK stride-1 window: paces pixel intake and tags each full window with its output coordinate.
import lenet_pkg::*;

module conv_window_ctrl #(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned K     = K_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  conv_window_ctrl_if.slave   win_if
);
  localparam int unsigned RW   = width_of(IMG_H - K + 32'd1);
  localparam int unsigned CW   = width_of(IMG_W - K + 32'd1);
  localparam int unsigned CRW  = width_of(IMG_H);
  localparam int unsigned CCW  = width_of(IMG_W);

  localparam logic [CRW-1:0] ROW_FIRST = CRW'(K - 32'd1);
  localparam logic [CCW-1:0] COL_FIRST = CCW'(K - 32'd1);

  state_t         state_r;
  logic           win_valid_r;
  logic [RW-1:0]  out_row_r;
  logic [CW-1:0]  out_col_r;
  logic           done_r;

  logic [CRW-1:0] row_s;
  logic [CCW-1:0] col_s;
  logic           col_wrap_s;
  logic           last_s;
  logic           pix_ready_s;
  logic           accept_s;
  logic           qual_s;
  logic           hs_s;
  logic           clr_s;

  assign pix_ready_s = (state_r == ST_RUN) & (~win_valid_r | win_if.win_ready);
  assign accept_s    = win_if.pix_valid & pix_ready_s;
  assign hs_s        = win_valid_r & win_if.win_ready;
  assign clr_s       = (state_r == ST_IDLE) & start;
  assign qual_s      = accept_s & (row_s >= ROW_FIRST) & (col_s >= COL_FIRST);

  wrap_counter #(.MAX(IMG_W - 32'd1), .W(CCW)) u_col_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clr_s),
    .en    (accept_s),
    .count (col_s),
    .wrap  (col_wrap_s)
  );

  // Row wraps only on the very last pixel of the frame, so its wrap marks frame end.
  wrap_counter #(.MAX(IMG_H - 32'd1), .W(CRW)) u_row_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clr_s),
    .en    (col_wrap_s),
    .count (row_s),
    .wrap  (last_s)
  );

  // Frame FSM with registered window flag, coordinates and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      win_valid_r <= 1'b0;
      out_row_r   <= '0;
      out_col_r   <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          win_valid_r <= 1'b0;
          state_r     <= start ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          if (qual_s) begin
            win_valid_r <= 1'b1;
            out_row_r   <= RW'(row_s - ROW_FIRST);
            out_col_r   <= CW'(col_s - COL_FIRST);
          end else if (hs_s) begin
            win_valid_r <= 1'b0;
          end else begin
            win_valid_r <= win_valid_r;
          end
          state_r <= last_s ? ST_DRAIN : ST_RUN;
        end
        ST_DRAIN: begin
          if (hs_s) begin
            win_valid_r <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_DRAIN;
          end
        end
        default: begin
          win_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign win_if.pix_ready = pix_ready_s;
  assign win_if.shift_en  = accept_s;
  assign win_if.win_valid = win_valid_r;
  assign win_if.out_row   = out_row_r;
  assign win_if.out_col   = out_col_r;
  assign busy             = (state_r != ST_IDLE);
  assign done             = done_r;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl at default geometry (32x32 image, 5x5 kernel).
module tb_conv_window_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  conv_window_ctrl_if #(.ROW_W(5), .COL_W(5)) bus ();

  conv_window_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .win_if (bus)
  );

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  int exp_r = 0;
  int exp_c = 0;
  bit seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_acc(input int target, input int bound);
    int n = 0;
    while (acc_cnt != target && n < bound) begin
      tick();
      n++;
    end
    chk("wait_acc", acc_cnt, target);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic frame_end_checks();
    tick();
    chk("done_single", done, 0);
    chk("busy_after", busy, 0);
    chk("win_count", win_cnt, 784);
    chk("acc_count", acc_cnt, 1024);
    chk("done_count", done_cnt, 1);
  endtask

  // Scoreboard: window sequence in raster order, accept count, done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        acc_cnt = 0; win_cnt = 0; done_cnt = 0; exp_r = 0; exp_c = 0; seen = 1'b0;
      end else begin
        if (start && !busy) begin
          acc_cnt = 0; win_cnt = 0; done_cnt = 0; exp_r = 0; exp_c = 0; seen = 1'b0;
        end
        chk("shift_en", bus.shift_en, bus.pix_valid & bus.pix_ready);
        if (bus.win_valid && !seen) begin
          seen = 1'b1;
          chk("first_win_acc", acc_cnt, 133);
        end
        if (bus.win_valid && bus.win_ready) begin
          chk("win_row", bus.out_row, exp_r);
          chk("win_col", bus.out_col, exp_c);
          win_cnt++;
          exp_c++;
          if (exp_c == 28) begin
            exp_c = 0;
            exp_r++;
          end
        end
        if (bus.pix_valid && bus.pix_ready) acc_cnt++;
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_shift_en", bus.shift_en, 0);
    chk("rst_win_valid", bus.win_valid, 0);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_out_col", bus.out_col, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_pix_ready", bus.pix_ready, 0);

    // Streaming frame: one accept per cycle.
    bus.pix_valid = 1'b1;
    bus.win_ready = 1'b1;
    pulse_start();
    chk("run_busy", busy, 1);
    chk("run_pix_ready", bus.pix_ready, 1);
    repeat (1024) tick();
    chk("stream_acc", acc_cnt, 1024);
    chk("drain_pix_ready", bus.pix_ready, 0);
    chk("drain_busy", busy, 1);
    chk("drain_row", bus.out_row, 27);
    chk("drain_col", bus.out_col, 27);
    tick();
    chk("stream_done", done, 1);
    chk("stream_busy0", busy, 0);
    frame_end_checks();

    // Downstream stall on window (10,7).
    pulse_start();
    begin
      int n = 0;
      while (!(bus.win_valid === 1'b1 && bus.out_row == 5'd10 && bus.out_col == 5'd7) && n < 2000) begin
        tick();
        n++;
      end
    end
    chk("found_10_7", bus.win_valid, 1);
    bus.win_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("stall_valid", bus.win_valid, 1);
      chk("stall_row", bus.out_row, 10);
      chk("stall_col", bus.out_col, 7);
      chk("stall_pix_ready", bus.pix_ready, 0);
      chk("stall_shift_en", bus.shift_en, 0);
      tick();
    end
    bus.win_ready = 1'b1;
    #1;
    chk("resume_pix_ready", bus.pix_ready, 1);
    wait_done(3000);
    frame_end_checks();

    // Random upstream bubbles.
    pulse_start();
    begin
      int n = 0;
      while (done !== 1'b1 && n < 6000) begin
        bus.pix_valid = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
    end
    bus.pix_valid = 1'b1;
    chk("bubble_done", done, 1);
    frame_end_checks();

    // start while busy is ignored.
    pulse_start();
    wait_acc(200, 1000);
    pulse_start();
    chk("ign_start_busy", busy, 1);
    wait_done(3000);
    frame_end_checks();

    // Reset mid-frame, then a fresh frame.
    pulse_start();
    wait_acc(500, 1000);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", bus.win_valid, 0);
    chk("mid_rst_pix_ready", bus.pix_ready, 0);
    chk("mid_rst_shift_en", bus.shift_en, 0);
    chk("mid_rst_row", bus.out_row, 0);
    chk("mid_rst_col", bus.out_col, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", busy, 0);
    pulse_start();
    wait_done(3000);
    frame_end_checks();

    // Last pixel accepted while downstream is not ready.
    pulse_start();
    wait_acc(1023, 2000);
    bus.pix_valid = 1'b0;
    tick();
    chk("pre_last_valid", bus.win_valid, 0);
    bus.win_ready = 1'b0;
    bus.pix_valid = 1'b1;
    #1;
    chk("pre_last_ready", bus.pix_ready, 1);
    tick();
    repeat (2) begin
      chk("dr_pix_ready", bus.pix_ready, 0);
      chk("dr_shift_en", bus.shift_en, 0);
      chk("dr_busy", busy, 1);
      chk("dr_valid", bus.win_valid, 1);
      chk("dr_row", bus.out_row, 27);
      chk("dr_col", bus.out_col, 27);
      chk("dr_done", done, 0);
      tick();
    end
    bus.win_ready = 1'b1;
    tick();
    chk("last_done", done, 1);
    chk("last_busy", busy, 0);
    chk("last_valid", bus.win_valid, 0);
    frame_end_checks();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
